// File: rtl/connect4_pkg.sv
// Shared Connect Four types: board geometry, cell codes, move status and FSM states.
package connect4_pkg;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;

  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10, HILITE = 2'b11} cell_t;

  typedef enum logic [2:0] {
    OK = 3'b000, WIN = 3'b001, DRAW = 3'b010, COL_FULL = 3'b011, BAD_REQ = 3'b100
  } status_t;

  typedef enum logic [2:0] {IDLE, SCAN, PLACE, CHK_POS, CHK_NEG, MARK, DONE} state_t;

  // Line directions as (row, col) steps: right, down, down-right, down-left.
  localparam logic signed [4:0] DIR_DR [4] = '{5'sd0, 5'sd1, 5'sd1,  5'sd1};
  localparam logic signed [4:0] DIR_DC [4] = '{5'sd1, 5'sd0, 5'sd1, -5'sd1};
endpackage

// File: rtl/board_probe.sv
// Bounds-checked cell compare: match when (row, col) lies on the board and holds player.
module board_probe #(
  parameter int ROWS = connect4_pkg::ROWS,
  parameter int COLS = connect4_pkg::COLS
) (
  input  logic [0:ROWS-1][0:COLS-1][1:0] board,
  input  logic signed [4:0]              row,
  input  logic signed [4:0]              col,
  input  logic [1:0]                     player,
  output logic                           match
);
  localparam logic signed [4:0] R_LIM = 5'(ROWS);
  localparam logic signed [4:0] C_LIM = 5'(COLS);

  logic       in_bounds;
  logic [2:0] ri, ci;

  // Index is forced to 0 when off-board so no probe aliases into another row/column.
  always_comb begin
    in_bounds = (row >= 5'sd0) && (row < R_LIM) && (col >= 5'sd0) && (col < C_LIM);
    ri        = in_bounds ? row[2:0] : 3'd0;
    ci        = in_bounds ? col[2:0] : 3'd0;
    match     = in_bounds && (board[ri][ci] == player);
  end
endmodule

// File: rtl/board_writer.sv
// Connect Four game-state engine: sole writer of the board, gravity drop, win scan/highlight,
// turn order, move count and game-over tracking.
module board_writer
  import connect4_pkg::*;
#(
  parameter int ROWS    = connect4_pkg::ROWS,
  parameter int COLS    = connect4_pkg::COLS,
  parameter int WIN_LEN = connect4_pkg::WIN_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           drop_valid,
  input  logic [2:0]                     drop_col,
  input  logic [1:0]                     drop_player,
  output logic                           drop_ready,
  output logic                           drop_done,
  output status_t                        drop_status,
  output logic [0:ROWS-1][0:COLS-1][1:0] board,
  output logic [1:0]                     next_player,
  output logic                           game_over,
  output logic [1:0]                     winner,
  output logic [5:0]                     moves
);
  state_t            state;
  logic [2:0]        r, col, count, m, cnt_next;
  logic [1:0]        player, dir, k, n;
  logic signed [4:0] dr, dc, off, pr, pc;
  logic              match, bad_req;

  assign drop_ready = (state == IDLE);
  assign cnt_next   = count + {2'b0, match};
  assign bad_req    = (drop_col >= 3'(COLS)) || !(drop_player == P1 || drop_player == P2) ||
                      (drop_player != next_player) || game_over;

  // One shared offset serves both probing (+/-k) and marking (m - n from the piece).
  always_comb begin
    dr = DIR_DR[dir];
    dc = DIR_DC[dir];
    case (state)
      CHK_POS: off = $signed({3'b0, k});
      CHK_NEG: off = -$signed({3'b0, k});
      MARK:    off = $signed({2'b0, m}) - $signed({3'b0, n});
      default: off = '0;
    endcase
    pr = $signed({2'b0, r})   + dr * off;
    pc = $signed({2'b0, col}) + dc * off;
  end

  board_probe #(.ROWS(ROWS), .COLS(COLS)) u_probe (
    .board(board), .row(pr), .col(pc), .player(player), .match(match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      board <= '0;  state <= IDLE;  next_player <= P1;  game_over <= 1'b0;
      winner <= EMPTY;  moves <= '0;  drop_status <= OK;  drop_done <= 1'b0;
      r <= '0;  col <= '0;  player <= '0;  dir <= '0;  k <= 2'd1;
      count <= 3'd1;  m <= '0;  n <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            board <= '0;  next_player <= P1;  game_over <= 1'b0;
            winner <= EMPTY;  moves <= '0;  drop_status <= OK;
          end else if (drop_valid) begin
            col    <= drop_col;
            player <= drop_player;
            r      <= 3'(ROWS - 1);
            if (bad_req) begin
              drop_status <= BAD_REQ;
              drop_done   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (board[r][col] == EMPTY) begin
            state <= PLACE;
          end else if (r == 3'd0) begin
            drop_status <= COL_FULL;
            drop_done   <= 1'b1;
            state       <= DONE;
          end else begin
            r <= r - 3'd1;
          end
        end
        PLACE: begin
          board[r][col] <= player;
          moves <= moves + 6'd1;
          dir   <= '0;
          count <= 3'd1;
          k     <= 2'd1;
          n     <= '0;
          state <= CHK_POS;
        end
        CHK_POS: begin
          if (match) count <= cnt_next;
          if (match && k != 2'd3) k <= k + 2'd1;
          else begin
            k     <= 2'd1;
            state <= CHK_NEG;
          end
        end
        CHK_NEG: begin
          if (match) begin
            count <= cnt_next;
            n     <= k;
          end
          if (match && k != 2'd3) k <= k + 2'd1;
          else begin
            k <= 2'd1;
            if (cnt_next >= 3'(WIN_LEN)) begin
              m     <= '0;
              state <= MARK;
            end else if (dir != 2'd3) begin
              dir   <= dir + 2'd1;
              count <= 3'd1;
              n     <= '0;
              state <= CHK_POS;
            end else begin
              drop_status <= (moves == 6'd42) ? DRAW : OK;
              drop_done   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        MARK: begin
          board[pr[2:0]][pc[2:0]] <= HILITE;
          if (m == count - 3'd1) begin
            game_over   <= 1'b1;
            winner      <= player;
            drop_status <= WIN;
            drop_done   <= 1'b1;
            state       <= DONE;
          end else begin
            m <= m + 3'd1;
          end
        end
        DONE: begin
          drop_done <= 1'b0;
          if (drop_status == OK)   next_player <= (next_player == P1) ? P2 : P1;
          if (drop_status == DRAW) game_over <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: turn flow, gravity, rejects, wins, draw, clear and reset abort.
module tb_board_writer;
  import connect4_pkg::*;

  logic             clk = 1'b0, rst = 1'b1, clear = 1'b0, drop_valid = 1'b0;
  logic [2:0]       drop_col = '0;
  logic [1:0]       drop_player = '0;
  logic             drop_ready, drop_done, game_over;
  status_t          drop_status;
  logic [0:5][0:6][1:0] board;
  logic [1:0]       next_player, winner;
  logic [5:0]       moves;
  int               passed = 0, total = 0;

  always #5 clk = ~clk;

  board_writer dut (
    .clk(clk), .rst(rst), .clear(clear), .drop_valid(drop_valid), .drop_col(drop_col),
    .drop_player(drop_player), .drop_ready(drop_ready), .drop_done(drop_done),
    .drop_status(drop_status), .board(board), .next_player(next_player),
    .game_over(game_over), .winner(winner), .moves(moves)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // elat = 0 skips the latency comparison; latency counts the accept cycle as 1.
  task automatic do_drop(input string tag, input logic [2:0] c, input logic [1:0] pl,
                         input logic [2:0] est, input int elat);
    int lat;
    @(negedge clk);
    drop_valid = 1'b1; drop_col = c; drop_player = pl;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    lat = 2;
    while (!drop_done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_status"}, drop_status, est);
    if (elat > 0) chk({tag, "_lat"}, lat, elat);
    @(posedge clk); #1;
    chk({tag, "_ready"}, drop_ready, 1'b1);
  endtask

  // Plays a column list with players alternating from P1; every move must be OK.
  task automatic play(input string tag, input int cs[$]);
    foreach (cs[i]) do_drop(tag, 3'(cs[i]), (i % 2 == 0) ? P1 : P2, OK, 0);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    int seq[$];
    int pairs[3][2];
    logic seen_done;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_ready", drop_ready, 1'b1);
    chk("rst_done", drop_done, 1'b0);
    chk("rst_status", drop_status, OK);
    chk("rst_board", board, '0);
    chk("rst_next", next_player, 2'b01);
    chk("rst_over", game_over, 1'b0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_moves", moves, 6'd0);

    // First move on empty board: 1 scan, 8 single-cycle checks.
    do_drop("first", 3'd3, P1, OK, 12);
    chk("first_cell", board[5][3], 2'b01);
    chk("first_next", next_player, 2'b10);
    chk("first_moves", moves, 6'd1);

    // Column fill then overflow.
    do_clear();
    chk("clr1_moves", moves, 6'd0);
    chk("clr1_next", next_player, 2'b01);
    for (int i = 0; i < 6; i++) do_drop("fill_c0", 3'd0, (i % 2 == 0) ? P1 : P2, OK, 12 + i);
    do_drop("col_full", 3'd0, P1, COL_FULL, 8);
    for (int rr = 0; rr < 6; rr++) chk("col_full_cell", board[rr][0], ((5 - rr) % 2 == 0) ? 2'b01 : 2'b10);
    chk("col_full_next", next_player, 2'b01);
    chk("col_full_moves", moves, 6'd6);

    // Malformed requests.
    do_drop("bad_col", 3'd7, P1, BAD_REQ, 2);
    do_drop("bad_pl", 3'd1, 2'b11, BAD_REQ, 2);
    do_drop("bad_turn", 3'd1, P2, BAD_REQ, 2);
    chk("bad_cell", board[5][1], 2'b00);
    chk("bad_moves", moves, 6'd6);
    chk("bad_next", next_player, 2'b01);

    // Horizontal win on the bottom row, piece at the right end.
    do_clear();
    play("h_setup", '{0, 0, 1, 1, 2, 2});
    do_drop("win_h", 3'd3, P1, WIN, 12);
    for (int cc = 0; cc < 4; cc++) chk("win_h_cell", board[5][cc], 2'b11);
    chk("win_h_p2", board[4][0], 2'b10);
    chk("win_h_winner", winner, 2'b01);
    chk("win_h_over", game_over, 1'b1);
    chk("win_h_moves", moves, 6'd7);
    chk("win_h_next", next_player, 2'b01);
    do_drop("after_win", 3'd5, P2, BAD_REQ, 2);

    // Down-right diagonal (2,0)..(5,3), closed at (4,2).
    do_clear();
    play("d_setup", '{3, 0, 0, 0, 0, 1, 6, 1, 1, 2});
    do_drop("win_diag", 3'd2, P1, WIN, 18);
    chk("diag_c0", board[2][0], 2'b11);
    chk("diag_c1", board[3][1], 2'b11);
    chk("diag_c2", board[4][2], 2'b11);
    chk("diag_c3", board[5][3], 2'b11);
    chk("diag_p2a", board[5][2], 2'b10);
    chk("diag_p2b", board[4][1], 2'b10);
    chk("diag_moves", moves, 6'd11);

    // Five-long run closed in the middle.
    do_clear();
    play("f_setup", '{0, 0, 1, 1, 3, 3, 4, 6});
    do_drop("win_5", 3'd2, P1, WIN, 15);
    for (int cc = 0; cc < 5; cc++) chk("win_5_cell", board[5][cc], 2'b11);
    chk("win_5_empty", board[5][5], 2'b00);
    chk("win_5_p2", board[5][6], 2'b10);

    // Full board with no line: column 5 alone, then paired columns.
    do_clear();
    seq = {};
    repeat (6) seq.push_back(5);
    pairs = '{'{0, 2}, '{1, 3}, '{4, 6}};
    for (int p = 0; p < 3; p++)
      repeat (3) begin
        seq.push_back(pairs[p][0]); seq.push_back(pairs[p][1]);
        seq.push_back(pairs[p][1]); seq.push_back(pairs[p][0]);
      end
    for (int i = 0; i < 41; i++) do_drop("draw_fill", 3'(seq[i]), (i % 2 == 0) ? P1 : P2, OK, 0);
    do_drop("draw", 3'(seq[41]), P2, DRAW, 19);
    chk("draw_over", game_over, 1'b1);
    chk("draw_moves", moves, 6'd42);
    chk("draw_winner", winner, 2'b00);
    chk("draw_next", next_player, 2'b10);
    chk("draw_c04", board[0][4], 2'b10);
    chk("draw_c06", board[0][6], 2'b01);
    chk("draw_c52", board[5][2], 2'b10);
    do_clear();
    chk("clr2_board", board, '0);
    chk("clr2_moves", moves, 6'd0);
    chk("clr2_next", next_player, 2'b01);
    chk("clr2_over", game_over, 1'b0);

    // Reset during the first positive-direction check.
    seen_done = 1'b0;
    @(negedge clk);
    drop_valid = 1'b1; drop_col = 3'd3; drop_player = P1;
    @(posedge clk); #1; drop_valid = 1'b0; seen_done |= drop_done;
    @(posedge clk); #1; seen_done |= drop_done;
    @(posedge clk); #1; seen_done |= drop_done;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; seen_done |= drop_done;
    chk("abort_ready", drop_ready, 1'b1);
    chk("abort_board", board, '0);
    chk("abort_moves", moves, 6'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen_done |= drop_done; end
    chk("abort_no_done", seen_done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
